// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
interface muldiv_unit_if;
  localparam int XLEN = 32;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] in_0;
  logic [XLEN-1:0] in_1;
  logic            kill;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] out;

  modport master (
    output start, op, in_0, in_1, kill,
    input  busy, out_valid, out
  );

  modport slave (
    input  start, op, in_0, in_1, kill,
    output busy, out_valid, out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply / restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial multiplies and small-quotient divides finish in one cycle.
module muldiv_unit (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int XLEN = 32;

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | 32 shift-add / restoring-divide iterations
  // FIX   | sign correction and result select
  // DONE  | out_valid pulse
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_res;
  logic [4:0]      cnt;
  logic [XLEN:0]   hi;
  logic [XLEN-1:0] lo;

  logic            a_signed, b_signed, sa, sb, is_div;
  logic [XLEN-1:0] amag_in, bmag_in;
  logic            div_zero, div_ovf, mul_zero, div_small, special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    is_div   = bus.op[2];
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sa       = a_signed & bus.in_0[XLEN-1];
    sb       = b_signed & bus.in_1[XLEN-1];
    amag_in  = sa ? -bus.in_0 : bus.in_0;
    bmag_in  = sb ? -bus.in_1 : bus.in_1;
    div_zero = is_div && (bus.in_1 == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.in_0 == 32'h8000_0000) &&
               (bus.in_1 == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
    mul_zero  = !is_div && ((bus.in_0 == '0) || (bus.in_1 == '0));
    div_small = is_div && (bmag_in > amag_in);
`else
    mul_zero  = 1'b0;
    div_small = 1'b0;
`endif
    special     = div_zero || div_ovf || mul_zero || div_small;
    special_val = '0;
    if (div_zero)
      special_val = bus.op[1] ? bus.in_0 : '1;
    else if (div_ovf)
      special_val = bus.op[1] ? '0 : 32'h8000_0000;
    else if (div_small)
      special_val = bus.op[1] ? bus.in_0 : '0;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_shift;
  logic [XLEN+1:0]   div_trial;
  logic              div_ge;

  // div_shift/div_trial carry one spare top bit so the trial sign is directly visible.
  always_comb begin
    mul_sum   = {1'b0, hi[XLEN-1:0]} + (lo[0] ? {1'b0, a_mag} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_trial = div_shift - {2'b00, b_mag};
    div_ge    = ~div_trial[XLEN+1];
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_res ? -{hi[XLEN-1:0], lo} : {hi[XLEN-1:0], lo};
    quo_fix  = neg_res ? -lo : lo;
    rem_fix  = neg_res ? -hi[XLEN-1:0] : hi[XLEN-1:0];
    case (op_q)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      a_mag         <= '0;
      b_mag         <= '0;
      neg_res       <= 1'b0;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.kill) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              op_q     <= bus.op;
              a_mag    <= amag_in;
              b_mag    <= bmag_in;
              neg_res  <= (bus.op[2] & bus.op[1]) ? sa : (sa ^ sb);
              cnt      <= '0;
              bus.busy <= 1'b1;
              if (special) begin
                bus.out       <= special_val;
                bus.out_valid <= 1'b1;
                state         <= DONE;
              end else begin
                hi    <= '0;
                lo    <= is_div ? amag_in : bmag_in;
                state <= CALC;
              end
            end
          end
          CALC: begin
            if (op_q[2]) begin
              hi <= div_ge ? div_trial[XLEN:0] : div_shift[XLEN:0];
              lo <= {lo[XLEN-2:0], div_ge};
            end else begin
              hi <= {1'b0, mul_sum[XLEN:1]};
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
              state <= FIX;
          end
          FIX: begin
            bus.out       <= fix_result;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
